// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin arbiter for the FP register file write port plus pending scoreboard.
// Define FP_WB_OUTREG_EN to register the write port (write lands one cycle after the handshake).
module fp_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic                      issue_i,
  input  logic [ADDR_W-1:0]         issue_rd_i,
  input  logic [ADDR_W-1:0]         freg1_i,
  input  logic [ADDR_W-1:0]         freg2_i,
  input  logic [ADDR_W-1:0]         freg3_i,
  output logic                      hazard_o,
  output logic                      fregwrite_o,
  output logic [ADDR_W-1:0]         frd_o,
  output logic [DATA_W-1:0]         writeback_data_o,
  output logic [31:0]               pending_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [PTR_W:0]     scan;
  logic [PTR_W-1:0]   gidx;
  logic               gvalid;
  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0]  gnt_rd;
  logic [DATA_W-1:0]  gnt_data;
  logic [31:0]        pend_q;
  logic [31:0]        pend_d;

  // Scan ptr, ptr+1, ... with wrap; no grant while in reset.
  always_comb begin
    gidx   = '0;
    gvalid = 1'b0;
    scan   = '0;
    gnt    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (scan >= (PTR_W+1)'(NUM_REQ))
        scan = scan - (PTR_W+1)'(NUM_REQ);
      if (rst_ni && !gvalid &&
          req_valid_i[scan[PTR_W-1:0]]) begin
        gvalid = 1'b1;
        gidx   = scan[PTR_W-1:0];
      end
    end
    if (gvalid)
      gnt[gidx] = 1'b1;
  end

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        gnt_rd   = req_rd_i[r*ADDR_W +: ADDR_W];
        gnt_data = req_data_i[r*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gvalid) begin
      if (gidx == PTR_W'(NUM_REQ-1))
        ptr_d = '0;
      else
        ptr_d = gidx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign req_ready_o = gnt;

`ifdef FP_WB_OUTREG_EN
  logic              we_q;
  logic [ADDR_W-1:0] frd_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      frd_q   <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= gvalid;
      frd_q   <= gnt_rd;
      wdata_q <= gnt_data;
    end
  end

  assign fregwrite_o      = we_q;
  assign frd_o            = frd_q;
  assign writeback_data_o = wdata_q;
`else
  assign fregwrite_o      = gvalid;
  assign frd_o            = gnt_rd;
  assign writeback_data_o = gnt_data;
`endif

  // Clear from the visible write port, then set: a new issue outranks the old result.
  always_comb begin
    pend_d = pend_q;
    if (fregwrite_o)
      pend_d[frd_o] = 1'b0;
    if (issue_i)
      pend_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

  assign pending_o = pend_q;
  assign hazard_o  = pend_q[freg1_i] | pend_q[freg2_i] |
                     pend_q[freg3_i] | pend_q[issue_rd_i];

  a_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_rdy_vld: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (req_ready_o & ~req_valid_i) == '0);

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: vector table, directed corner sequences and randomized
// traffic against a queue/array reference model of the writeback arbiter.
module tb_fp_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic [N*AW-1:0] rd;
  logic [N*DW-1:0] data;
  logic            issue;
  logic [AW-1:0]   ird, f1, f2, f3;
  logic            hz, we;
  logic [AW-1:0]   frd;
  logic [DW-1:0]   wdata;
  logic [31:0]     pend;

  fp_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_rd_i(rd), .req_data_i(data),
    .issue_i(issue), .issue_rd_i(ird),
    .freg1_i(f1), .freg2_i(f2), .freg3_i(f3),
    .hazard_o(hz), .fregwrite_o(we), .frd_o(frd),
    .writeback_data_o(wdata), .pending_o(pend)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int            m_ptr;
  bit            m_pend[32];
  bit            m_wv;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;

  logic [N-1:0]  s_ready;
  logic          s_we, s_hz;
  logic [AW-1:0] s_frd;
  logic [31:0]   s_pend;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_wv = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  function automatic int model_grant();
    int idx;
    if (!rst_n) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Inputs are stable from posedge+1; compare at negedge; advance the model at posedge.
  task automatic cycle();
    int            g;
    logic [N-1:0]  er;
    logic          ewe, eh;
    logic [AW-1:0] ea, ga;
    logic [DW-1:0] ed, gd;
    logic [31:0]   ep;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    ga = '0;
    gd = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ga = rd[g*AW +: AW];
      gd = data[g*DW +: DW];
    end
`ifdef FP_WB_OUTREG_EN
    ewe = m_wv;
    ea  = m_wa;
    ed  = m_wd;
`else
    ewe = (g >= 0);
    ea  = ga;
    ed  = gd;
`endif
    for (int i = 0; i < 32; i++) ep[i] = m_pend[i];
    eh = m_pend[f1] | m_pend[f2] | m_pend[f3] | m_pend[ird];
    s_ready = ready;
    s_we    = we;
    s_frd   = frd;
    s_hz    = hz;
    s_pend  = pend;
    check("ready", ready, er);
    check("fregwrite", we, ewe);
    check("frd", frd, ea);
    check("wdata", wdata, ed);
    check("pending", pend, ep);
    check("hazard", hz, eh);
    @(posedge clk);
    if (rst_n) begin
      if (g >= 0) m_ptr = (g + 1) % N;
      if (ewe) m_pend[ea] = 1'b0;
      if (issue) m_pend[ird] = 1'b1;
      m_wv = (g >= 0);
      m_wa = ga;
      m_wd = gd;
    end
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic is,
                        input logic [AW-1:0] ir,
                        input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [AW-1:0] c);
    valid = v;
    issue = is;
    ird   = ir;
    f1    = a;
    f2    = b;
    f3    = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(3'b111, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    check("rst_ready", s_ready, 3'b000);
    check("rst_we", s_we, 1'b0);
    check("rst_pend", s_pend, 32'h0);
    check("rst_hz", s_hz, 1'b0);
    rst_n = 1'b1;
    set_in(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  r;
    logic [AW-1:0] frd;
  } vec_t;
  vec_t tbl[12];

  int            waitc[N];
  logic [AW-1:0] prev_frd;
  logic [AW-1:0] exp_frd;

  initial begin
    rst_n = 1'b0;
    set_in(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    rd    = {5'd12, 5'd11, 5'd10};
    data  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    tbl[0]  = '{3'b111, 3'b001, 5'd10};
    tbl[1]  = '{3'b111, 3'b010, 5'd11};
    tbl[2]  = '{3'b111, 3'b100, 5'd12};
    tbl[3]  = '{3'b111, 3'b001, 5'd10};
    tbl[4]  = '{3'b111, 3'b010, 5'd11};
    tbl[5]  = '{3'b111, 3'b100, 5'd12};
    tbl[6]  = '{3'b000, 3'b000, 5'd0};
    tbl[7]  = '{3'b100, 3'b100, 5'd12};
    tbl[8]  = '{3'b101, 3'b001, 5'd10};
    tbl[9]  = '{3'b110, 3'b010, 5'd11};
    tbl[10] = '{3'b011, 3'b001, 5'd10};
    tbl[11] = '{3'b011, 3'b010, 5'd11};
    prev_frd = '0;
    for (int i = 0; i < 12; i++) begin
      valid = tbl[i].v;
      cycle();
      check("tbl_ready", s_ready, tbl[i].r);
`ifdef FP_WB_OUTREG_EN
      exp_frd = prev_frd;
`else
      exp_frd = tbl[i].frd;
`endif
      check("tbl_frd", s_frd, exp_frd);
      prev_frd = tbl[i].frd;
    end

    // RAW on f7, cleared by a writeback from r1
    do_reset();
    set_in(3'b000, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0);
    cycle();
    set_in(3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0);
    cycle();
    check("raw_hz", s_hz, 1'b1);
    rd = {5'd12, 5'd7, 5'd10};
    set_in(3'b010, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0);
    cycle();
    check("raw_hz_wb", s_hz, 1'b1);
    set_in(3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 5'd0);
    cycle();
`ifdef FP_WB_OUTREG_EN
    check("raw_we_late", s_we, 1'b1);
    check("raw_hz_late", s_hz, 1'b1);
    cycle();
`endif
    check("raw_clear", s_pend[7], 1'b0);
    check("raw_hz_gone", s_hz, 1'b0);

    // set wins over a same-cycle writeback of the same register
    do_reset();
    rd = {5'd12, 5'd11, 5'd9};
`ifdef FP_WB_OUTREG_EN
    set_in(3'b001, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
    cycle();
`else
    set_in(3'b000, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
    cycle();
    set_in(3'b001, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
`endif
    cycle();
    set_in(3'b000, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0);
`ifdef FP_WB_OUTREG_EN
    cycle();
`else
    check("sw_we", s_we, 1'b1);
    check("sw_frd", s_frd, 5'd9);
`endif
`ifdef FP_WB_OUTREG_EN
    check("sw_we", s_we, 1'b1);
    check("sw_frd", s_frd, 5'd9);
`endif
    set_in(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    cycle();
    check("setwins", s_pend[9], 1'b1);

    // WAW: destination pending, sources clean
    set_in(3'b000, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0);
    cycle();
    set_in(3'b000, 1'b1, 5'd5, 5'd1, 5'd2, 5'd3);
    cycle();
    check("waw_none", s_hz, 1'b0);
    set_in(3'b000, 1'b1, 5'd4, 5'd1, 5'd2, 5'd3);
    cycle();
    check("waw_hz", s_hz, 1'b1);

    // async reset in the middle of a burst
    rd = {5'd12, 5'd11, 5'd10};
    set_in(3'b111, 1'b1, 5'd20, 5'd0, 5'd0, 5'd0);
    cycle();
    set_in(3'b111, 1'b0, 5'd0, 5'd20, 5'd0, 5'd0);
    cycle();
    check("burst_hz", s_hz, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pend", pend, 32'h0);
    check("mid_rst_ready", ready, 3'b000);
    check("mid_rst_hz", hz, 1'b0);
    check("mid_rst_we", we, 1'b0);
    model_reset();
    cycle();
    rst_n = 1'b1;

    // randomized traffic; requesters hold until granted
    for (int r = 0; r < N; r++) waitc[r] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!valid[r] || s_ready[r]) begin
          valid[r] = ($urandom_range(0, 3) != 0);
          rd[r*AW +: AW]   = AW'($urandom_range(0, 7));
          data[r*DW +: DW] = $urandom;
        end
      end
      issue = $urandom_range(0, 1) == 1;
      ird   = AW'($urandom_range(0, 7));
      f1    = AW'($urandom_range(0, 7));
      f2    = AW'($urandom_range(0, 7));
      f3    = AW'($urandom_range(0, 7));
      cycle();
      for (int r = 0; r < N; r++) begin
        if (s_ready[r]) begin
          check("starve", waitc[r] <= N - 1, 1'b1);
          waitc[r] = 0;
        end else if (valid[r]) begin
          waitc[r]++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
